fast_fifo_stream_reader: RTL and testbench



---
 rtl/fast_fifo_stream_reader.sv | 141 ++++++++++++++
 tb/tb_fast_fifo_stream_reader.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fast_fifo_stream_reader.sv
// Consumer-side adapter for a fixed-latency FIFO read port: issues speculative reads,
// catches returns in a register skid buffer and presents them as a valid/ready stream.
module fast_fifo_stream_reader #(
    parameter int unsigned WIDTH        = 20,
    parameter int unsigned READ_LATENCY = 2,
    parameter int unsigned BUF_DEPTH    = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    output logic                             fifoReadRequest,
    input  logic [WIDTH-1:0]                 fifoDataOut,
    input  logic                             fifoDataOutValid,
    input  logic                             fifoEccStatus,
    output logic [WIDTH-1:0]                 outData,
    output logic                             outValid,
    input  logic                             outReady,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   occupancy,
    output logic                             eccError,
    output logic                             protocolError
);

    localparam int unsigned OCC_W  = $clog2(BUF_DEPTH + 1);
    localparam int unsigned PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned PIPE_W = (READ_LATENCY > 0) ? READ_LATENCY : 1;
    localparam int unsigned DRN_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
    localparam int unsigned CNT_W  = $clog2(BUF_DEPTH + PIPE_W + 1) + 1;

    logic [PIPE_W-1:0] req_pipe_q, req_pipe_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              valid_q, valid_d;
    logic              ecc_q, ecc_d;
    logic              perr_q, perr_d;
    logic [WIDTH-1:0]  buf_q [BUF_DEPTH];

    logic [CNT_W-1:0]  inflight;
    logic              draining;
    logic              expected;
    logic              wr_en;
    logic              pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Requests still travelling through the FIFO read pipeline
    always_comb begin
        inflight = '0;
        for (int i = 0; i < PIPE_W; i++) begin
            inflight = inflight + CNT_W'(req_pipe_q[i]);
        end
    end

    assign draining        = (drain_q != '0);
    assign fifoReadRequest = !rst && !draining &&
                             ((CNT_W'(occ_q) + inflight) < CNT_W'(BUF_DEPTH));

    if (READ_LATENCY == 0) begin : g_lat0
        assign expected = fifoReadRequest;
    end else begin : g_latn
        assign expected = req_pipe_q[PIPE_W-1];
    end

    assign wr_en = fifoDataOutValid && expected && !draining && !rst;
    assign pop   = valid_q && outReady;

    // Next-state: request tracking, buffer pointers, occupancy and sticky flags
    always_comb begin
        req_pipe_d = '0;
        drain_d    = drain_q;
        head_d     = head_q;
        tail_d     = tail_q;
        occ_d      = occ_q;
        valid_d    = valid_q;
        ecc_d      = ecc_q;
        perr_d     = perr_q;
        if (rst) begin
            drain_d = DRN_W'(READ_LATENCY);
            head_d  = '0;
            tail_d  = '0;
            occ_d   = '0;
            valid_d = 1'b0;
            ecc_d   = 1'b0;
            perr_d  = 1'b0;
        end else begin
            if (draining) begin
                drain_d = drain_q - DRN_W'(1);
            end
            if (READ_LATENCY != 0) begin
                req_pipe_d = (req_pipe_q << 1) | PIPE_W'(fifoReadRequest);
            end
            if (wr_en) begin
                tail_d = ptr_inc(tail_q);
            end
            if (pop) begin
                head_d = ptr_inc(head_q);
            end
            occ_d   = occ_q + OCC_W'(wr_en) - OCC_W'(pop);
            valid_d = (occ_d != '0);
            // Returns during the post-reset drain belong to pre-reset requests
            if (fifoDataOutValid && !draining) begin
                if (fifoEccStatus) begin
                    ecc_d = 1'b1;
                end
                if (!expected) begin
                    perr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        req_pipe_q <= req_pipe_d;
        drain_q    <= drain_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        occ_q      <= occ_d;
        valid_q    <= valid_d;
        ecc_q      <= ecc_d;
        perr_q     <= perr_d;
    end

    // Skid buffer storage; contents are meaningless beyond occupancy
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[tail_q] <= fifoDataOut;
        end
    end

    assign outData       = buf_q[head_q];
    assign outValid      = valid_q;
    assign occupancy     = occ_q;
    assign eccError      = ecc_q;
    assign protocolError = perr_q;

endmodule

// File: tb/tb_fast_fifo_stream_reader.sv
// Bench for fast_fifo_stream_reader: latency-2 FIFO model, scoreboard of FIFO write order,
// cycle table for the start-up stream and directed corner-case sequences.
module tb_fast_fifo_stream_reader;

    logic        clk;
    logic        rst;
    logic        fifoReadRequest;
    logic [19:0] fifoDataOut;
    logic        fifoDataOutValid;
    logic        fifoEccStatus;
    logic [19:0] outData;
    logic        outValid;
    logic        outReady;
    logic [2:0]  occupancy;
    logic        eccError;
    logic        protocolError;

    fast_fifo_stream_reader #(
        .WIDTH        (20),
        .READ_LATENCY (2),
        .BUF_DEPTH    (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fifoReadRequest  (fifoReadRequest),
        .fifoDataOut      (fifoDataOut),
        .fifoDataOutValid (fifoDataOutValid),
        .fifoEccStatus    (fifoEccStatus),
        .outData          (outData),
        .outValid         (outValid),
        .outReady         (outReady),
        .occupancy        (occupancy),
        .eccError         (eccError),
        .protocolError    (protocolError)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO model with a 2-cycle read pipeline; it is never reset by the reader's rst
    logic [19:0] fmem [256];
    logic [7:0]  wr_ptr = '0;
    logic [7:0]  rd_ptr = '0;
    logic [1:0]  fp_v   = '0;
    logic [1:0]  fp_e   = '0;
    logic [19:0] fp_d0  = '0;
    logic [19:0] fp_d1  = '0;
    logic [19:0] ecc_word;
    logic        inj_valid;

    always @(posedge clk) begin
        fp_v[1] <= fp_v[0];
        fp_e[1] <= fp_e[0];
        fp_d1   <= fp_d0;
        if (fifoReadRequest && (rd_ptr != wr_ptr)) begin
            fp_v[0] <= 1'b1;
            fp_e[0] <= (fmem[rd_ptr] == ecc_word);
            fp_d0   <= fmem[rd_ptr];
            rd_ptr  <= rd_ptr + 8'd1;
        end else begin
            fp_v[0] <= 1'b0;
            fp_e[0] <= 1'b0;
        end
    end

    assign fifoDataOutValid = fp_v[1] | inj_valid;
    assign fifoEccStatus    = fp_e[1];
    assign fifoDataOut      = fp_d1;

    typedef struct {
        logic        rdy;
        logic        req;
        logic        vld;
        logic [19:0] dat;
    } vec_t;

    vec_t        vecs [16];
    logic [19:0] exp_q [$];
    int          total = 0;
    int          bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_word(input logic [19:0] w);
        fmem[wr_ptr] = w;
        wr_ptr = wr_ptr + 8'd1;
        exp_q.push_back(w);
    endtask

    // Compare any transfer happening at the coming edge, then advance one cycle
    task automatic step();
        logic [19:0] w;
        if (!rst && outValid && outReady) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_extra: got word %0h, none required", outData);
            end else begin
                w = exp_q.pop_front();
                chk("sb_data", 32'(outData), 32'(w));
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("occ_bound", 32'(occupancy <= 3'd4), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_q.delete();
        step();
        chk("rst_req", 32'(fifoReadRequest), 32'd0);
        step();
        rst = 1'b0;
        chk("rst_valid", 32'(outValid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ecc", 32'(eccError), 32'd0);
        chk("rst_perr", 32'(protocolError), 32'd0);
    endtask

    task automatic drain_all(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            step();
        end
        chk(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int nreq;

        // Start-up stream: cycle c after reset release, c = 2..17
        for (int i = 0; i < 16; i++) begin
            vecs[i].rdy = 1'b1;
            vecs[i].req = (i + 2 >= 3);
            vecs[i].vld = (i + 2 >= 6) && (i + 2 <= 15);
            vecs[i].dat = vecs[i].vld ? 20'(i + 2 - 5) : 20'h0;
        end

        rst       = 1'b1;
        outReady  = 1'b0;
        inj_valid = 1'b0;
        ecc_word  = 20'hFFFFF;
        @(negedge clk);

        // Streaming with outReady held high
        do_reset();
        for (int w = 1; w <= 10; w++) push_word(20'(w));
        for (int i = 0; i < 16; i++) begin
            step();
            outReady = vecs[i].rdy;
            chk($sformatf("t1_req_c%0d", i + 2), 32'(fifoReadRequest), 32'(vecs[i].req));
            chk($sformatf("t1_vld_c%0d", i + 2), 32'(outValid), 32'(vecs[i].vld));
            if (vecs[i].vld) begin
                chk($sformatf("t1_dat_c%0d", i + 2), 32'(outData), 32'(vecs[i].dat));
            end
        end
        chk("t1_left", 32'(exp_q.size()), 32'd0);

        // Backpressure: buffer fills, requests stop, head word held
        outReady = 1'b0;
        do_reset();
        for (int w = 1; w <= 10; w++) push_word(20'(w));
        nreq = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (fifoReadRequest) nreq++;
        end
        chk("t2_nreq", 32'(nreq), 32'd4);
        chk("t2_occ", 32'(occupancy), 32'd4);
        chk("t2_req_off", 32'(fifoReadRequest), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("t2_hold_vld", 32'(outValid), 32'd1);
            chk("t2_hold_dat", 32'(outData), 32'h1);
        end
        outReady = 1'b1;
        drain_all("t2_drain", 60);

        // FIFO empty while speculative requests continue, then one late word
        nreq = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (fifoReadRequest) nreq++;
            chk("t3_empty_vld", 32'(outValid), 32'd0);
        end
        chk("t3_spec_req", 32'(nreq > 0), 32'd1);
        push_word(20'h55);
        drain_all("t3_late", 20);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t3_once", 32'(outValid), 32'd0);
        end
        chk("t3_perr", 32'(protocolError), 32'd0);

        // Unexpected return while nothing is in flight
        outReady = 1'b0;
        for (int w = 0; w < 4; w++) push_word(20'h41 + 20'(w));
        for (int i = 0; i < 20 && occupancy != 3'd4; i++) step();
        chk("t4_full", 32'(occupancy), 32'd4);
        for (int i = 0; i < 3; i++) step();
        chk("t4_noreq", 32'(fifoReadRequest), 32'd0);
        chk("t4_perr_pre", 32'(protocolError), 32'd0);
        inj_valid = 1'b1;
        step();
        inj_valid = 1'b0;
        chk("t4_perr", 32'(protocolError), 32'd1);
        chk("t4_occ", 32'(occupancy), 32'd4);
        for (int i = 0; i < 3; i++) step();
        chk("t4_perr_sticky", 32'(protocolError), 32'd1);
        do_reset();

        // ECC flag on word 0x3: word still delivered, flag sticky
        ecc_word = 20'h3;
        outReady = 1'b1;
        for (int w = 1; w <= 5; w++) push_word(20'(w));
        drain_all("t5_drain", 40);
        chk("t5_ecc", 32'(eccError), 32'd1);
        for (int i = 0; i < 3; i++) step();
        chk("t5_ecc_sticky", 32'(eccError), 32'd1);
        chk("t5_perr", 32'(protocolError), 32'd0);

        // Reset with words buffered and two requests in flight
        ecc_word = 20'hFFFFF;
        outReady = 1'b0;
        do_reset();
        for (int w = 0; w < 5; w++) push_word(20'h61 + 20'(w));
        for (int i = 0; i < 6; i++) step();
        chk("t6_occ_pre", 32'(occupancy), 32'd2);
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(20'h65);
        step();
        chk("t6_rst_vld", 32'(outValid), 32'd0);
        chk("t6_rst_occ", 32'(occupancy), 32'd0);
        rst = 1'b0;
        outReady = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t6_drain_occ", 32'(occupancy), 32'd0);
            chk("t6_drain_perr", 32'(protocolError), 32'd0);
        end
        drain_all("t6_resume", 20);
        chk("t6_perr_end", 32'(protocolError), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
